// File: rtl/mem_access_unit_if.sv
// Core-side strobes plus memory-bus handshake for mem_access_unit.
// slave is the unit's view; master is the view of the core and memory that surround it.
interface mem_access_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        err_clr;
  logic        Mem_req;
  logic        Mem_we;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_wdata;
  logic        Mem_ack;
  logic [31:0] Mem_rdata;
  logic [31:0] Instruction;
  logic [31:0] MDR;
  logic        mem_stall;
  logic        bus_err;

  modport slave (
    input  MemRead, MemWrite, IRWrite, Address, Write_data, err_clr, Mem_ack, Mem_rdata,
    output Mem_req, Mem_we, Mem_addr, Mem_wdata, Instruction, MDR, mem_stall, bus_err
  );

  modport master (
    output MemRead, MemWrite, IRWrite, Address, Write_data, err_clr, Mem_ack, Mem_rdata,
    input  Mem_req, Mem_we, Mem_addr, Mem_wdata, Instruction, MDR, mem_stall, bus_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Bridges a multicycle core's memory strobes onto a req/ack bus, stalling the core until done.
// A bus that never acks raises a sticky bus_err and the target register is loaded with 0.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  mem_access_unit_if.slave   bus_io
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        fetch_q, fetch_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic strobe;
  logic unused_addr_lsb;

  assign strobe          = bus_io.MemRead | bus_io.MemWrite;
  assign unused_addr_lsb = ^bus_io.Address[1:0];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    fetch_d = fetch_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // Clear first so that a timeout in the same cycle overrides it.
    if (bus_io.err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          state_d = StBusy;
          req_d   = 1'b1;
          addr_d  = {bus_io.Address[31:2], 2'b00};
          wdata_d = bus_io.Write_data;
          we_d    = bus_io.MemWrite & ~bus_io.MemRead;
          fetch_d = bus_io.IRWrite & bus_io.MemRead;
          cnt_d   = 8'd0;
        end
      end
      StBusy: begin
        if (bus_io.Mem_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) begin
            if (fetch_q) begin
              instr_d = bus_io.Mem_rdata;
            end else begin
              mdr_d = bus_io.Mem_rdata;
            end
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StDone;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) begin
            if (fetch_q) begin
              instr_d = 32'd0;
            end else begin
              mdr_d = 32'd0;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      instr_q <= 32'd0;
      mdr_q   <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.Mem_req     = req_q;
  assign bus_io.Mem_we      = we_q;
  assign bus_io.Mem_addr    = addr_q;
  assign bus_io.Mem_wdata   = wdata_q;
  assign bus_io.Instruction = instr_q;
  assign bus_io.MDR         = mdr_q;
  assign bus_io.bus_err     = err_q;
  assign bus_io.mem_stall   = ((state_q == StIdle) & strobe) | (state_q == StBusy);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4: fetch, waited store, conflict,
// DONE strobes, timeouts, err_clr priority and reset mid-access.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_access_unit_if bus_if ();

  mem_access_unit #(
    .TIMEOUT(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] instr,
                                  input logic [31:0] mdr);
    chk({tag, " req"}, {31'd0, bus_if.Mem_req}, 32'd0);
    chk({tag, " stall"}, {31'd0, bus_if.mem_stall}, 32'd0);
    chk({tag, " instr"}, bus_if.Instruction, instr);
    chk({tag, " mdr"}, bus_if.MDR, mdr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst                = 1'b0;
    bus_if.MemRead     = 1'b0;
    bus_if.MemWrite    = 1'b0;
    bus_if.IRWrite     = 1'b0;
    bus_if.Address     = 32'd0;
    bus_if.Write_data  = 32'd0;
    bus_if.err_clr     = 1'b0;
    bus_if.Mem_ack     = 1'b0;
    bus_if.Mem_rdata   = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst we", {31'd0, bus_if.Mem_we}, 32'd0);
    chk("rst addr", bus_if.Mem_addr, 32'd0);
    chk("rst wdata", bus_if.Mem_wdata, 32'd0);
    chk("rst err", {31'd0, bus_if.bus_err}, 32'd0);
    chk_idle_outputs("rst", 32'd0, 32'd0);
    rst = 1'b1;

    // Fetch, zero wait
    @(negedge clk);
    bus_if.MemRead = 1'b1;
    bus_if.IRWrite = 1'b1;
    bus_if.Address = 32'h0000_0104;
    #1;
    chk("fetch idle stall", {31'd0, bus_if.mem_stall}, 32'd1);
    chk("fetch idle req", {31'd0, bus_if.Mem_req}, 32'd0);
    @(negedge clk);
    bus_if.MemRead = 1'b0;
    bus_if.IRWrite = 1'b0;
    chk("fetch busy req", {31'd0, bus_if.Mem_req}, 32'd1);
    chk("fetch busy addr", bus_if.Mem_addr, 32'h0000_0104);
    chk("fetch busy we", {31'd0, bus_if.Mem_we}, 32'd0);
    chk("fetch busy stall", {31'd0, bus_if.mem_stall}, 32'd1);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 32'h8C22_0004;
    @(negedge clk);
    bus_if.Mem_ack = 1'b0;
    chk_idle_outputs("fetch done", 32'h8C22_0004, 32'd0);

    // Store with 3 wait cycles; rdata on ack must be ignored
    @(negedge clk);
    bus_if.MemWrite   = 1'b1;
    bus_if.Address    = 32'h0000_0203;
    bus_if.Write_data = 32'hDEAD_BEEF;
    #1;
    chk("store idle stall", {31'd0, bus_if.mem_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.MemWrite = 1'b0;
      chk("store req", {31'd0, bus_if.Mem_req}, 32'd1);
      chk("store stall", {31'd0, bus_if.mem_stall}, 32'd1);
      chk("store addr", bus_if.Mem_addr, 32'h0000_0200);
      chk("store we", {31'd0, bus_if.Mem_we}, 32'd1);
      chk("store wdata", bus_if.Mem_wdata, 32'hDEAD_BEEF);
      if (i == 3) begin
        bus_if.Mem_ack   = 1'b1;
        bus_if.Mem_rdata = 32'h1234_5678;
      end
    end
    @(negedge clk);
    bus_if.Mem_ack = 1'b0;
    chk_idle_outputs("store done", 32'h8C22_0004, 32'd0);

    // Read/write conflict, strobes held through DONE
    @(negedge clk);
    bus_if.MemRead    = 1'b1;
    bus_if.MemWrite   = 1'b1;
    bus_if.Address    = 32'h0000_0400;
    bus_if.Write_data = 32'h0000_0055;
    @(negedge clk);
    chk("conf busy we", {31'd0, bus_if.Mem_we}, 32'd0);
    chk("conf busy addr", bus_if.Mem_addr, 32'h0000_0400);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    chk_idle_outputs("conf done", 32'h8C22_0004, 32'hA5A5_0001);
    bus_if.Mem_ack = 1'b0;
    @(negedge clk);
    chk("conf idle after done req", {31'd0, bus_if.Mem_req}, 32'd0);
    chk("conf idle after done stall", {31'd0, bus_if.mem_stall}, 32'd1);
    @(negedge clk);
    bus_if.MemRead  = 1'b0;
    bus_if.MemWrite = 1'b0;
    chk("conf second req", {31'd0, bus_if.Mem_req}, 32'd1);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 32'hA5A5_0002;
    @(negedge clk);
    bus_if.Mem_ack = 1'b0;
    chk_idle_outputs("conf second done", 32'h8C22_0004, 32'hA5A5_0002);

    // Timeout on a data read
    @(negedge clk);
    bus_if.MemRead = 1'b1;
    bus_if.Address = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.MemRead = 1'b0;
      chk("tmo req", {31'd0, bus_if.Mem_req}, 32'd1);
      chk("tmo err low", {31'd0, bus_if.bus_err}, 32'd0);
    end
    @(negedge clk);
    chk("tmo err set", {31'd0, bus_if.bus_err}, 32'd1);
    chk_idle_outputs("tmo done", 32'h8C22_0004, 32'd0);
    @(negedge clk);
    chk("tmo err sticky", {31'd0, bus_if.bus_err}, 32'd1);
    bus_if.err_clr = 1'b1;
    @(negedge clk);
    bus_if.err_clr = 1'b0;
    chk("tmo err cleared", {31'd0, bus_if.bus_err}, 32'd0);

    // Timeout while err_clr is held: set wins
    bus_if.MemRead = 1'b1;
    bus_if.err_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.MemRead = 1'b0;
    end
    @(negedge clk);
    chk("tmo set wins", {31'd0, bus_if.bus_err}, 32'd1);
    @(negedge clk);
    chk("tmo clr after", {31'd0, bus_if.bus_err}, 32'd0);
    bus_if.err_clr = 1'b0;

    // Reset in the 2nd BUSY cycle
    bus_if.MemRead = 1'b1;
    bus_if.IRWrite = 1'b1;
    bus_if.Address = 32'h0000_0500;
    @(negedge clk);
    bus_if.MemRead = 1'b0;
    bus_if.IRWrite = 1'b0;
    chk("rmid busy1 req", {31'd0, bus_if.Mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmid req", {31'd0, bus_if.Mem_req}, 32'd0);
    chk("rmid addr", bus_if.Mem_addr, 32'd0);
    chk("rmid wdata", bus_if.Mem_wdata, 32'd0);
    chk_idle_outputs("rmid", 32'd0, 32'd0);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outputs("rmid late ack", 32'd0, 32'd0);
    bus_if.Mem_ack = 1'b0;

    // First access after reset recognised on the first edge
    bus_if.MemRead = 1'b1;
    bus_if.Address = 32'h0000_0600;
    @(negedge clk);
    bus_if.MemRead = 1'b0;
    chk("post rst req", {31'd0, bus_if.Mem_req}, 32'd1);
    chk("post rst addr", bus_if.Mem_addr, 32'h0000_0600);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus_if.Mem_ack = 1'b0;
    chk_idle_outputs("post rst done", 32'd0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles before a bus error is declared (legal range 1..255).
REQ-002 The block SHALL have port clk, in, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, in, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port MemRead, in, 1, the core's read strobe.
REQ-005 The block SHALL have port MemWrite, in, 1, the core's write strobe.
REQ-006 The block SHALL have port IRWrite, in, 1, marking a read as an instruction fetch.
REQ-007 The block SHALL have port Address, in, 32, the core's byte address.
REQ-008 The block SHALL have port Write_data, in, 32, the core's store data.
REQ-009 The block SHALL have port err_clr, in, 1, which clears bus_err.
REQ-010 The block SHALL have port Mem_req, out, 1, the bus request.
REQ-011 The block SHALL have port Mem_we, out, 1, the bus write enable.
REQ-012 The block SHALL have port Mem_addr, out, 32, the word-aligned bus address.
REQ-013 The block SHALL have port Mem_wdata, out, 32, the bus write data.
REQ-014 The block SHALL have port Mem_ack, in, 1, the bus completion signal.
REQ-015 The block SHALL have port Mem_rdata, in, 32, the bus read data.
REQ-016 The block SHALL have port Instruction, out, 32, the instruction register.
REQ-017 The block SHALL have port MDR, out, 32, the memory data register.
REQ-018 The block SHALL have port mem_stall, out, 1, telling the core to hold its FSM state.
REQ-019 The block SHALL have port bus_err, out, 1, a sticky error flag.

Function
REQ-020 The block SHALL implement a 3-state FSM with states IDLE, BUSY and DONE.
REQ-021 In IDLE, when MemRead or MemWrite is 1, the block SHALL capture the following at the clock edge and go to BUSY: Address with bits [1:0] forced to 00, Write_data, we = MemWrite & ~MemRead, and fetch = IRWrite & MemRead.
REQ-022 If MemRead and MemWrite are both 1, the block SHALL perform the read and suppress the write.
REQ-023 mem_stall SHALL equal (IDLE & (MemRead | MemWrite)) | BUSY, combinationally; it SHALL be 0 in DONE.
REQ-024 Mem_req SHALL be registered and equal 1 exactly while in BUSY; Mem_we, Mem_addr and Mem_wdata SHALL hold the captured values throughout BUSY.
REQ-025 In BUSY, when Mem_ack is 1, the FSM SHALL go to DONE. On a read, Mem_rdata SHALL be loaded into Instruction if fetch is set, else into MDR. Writes SHALL load neither register.
REQ-026 An ack on the first BUSY cycle SHALL be accepted; this gives a minimum stall of 2 cycles, and the loaded data is visible in the DONE cycle.
REQ-027 The wait counter (8 bits) SHALL clear on entry to BUSY and increment on each BUSY cycle without ack.
REQ-028 If the counter equals TIMEOUT-1 and Mem_ack is 0, the block SHALL set bus_err, load 0 into the selected register on a read, and go to DONE.
REQ-029 DONE SHALL last exactly one cycle, then go unconditionally to IDLE; strobes seen in DONE SHALL NOT start an access.
REQ-030 Mem_ack SHALL be ignored in IDLE and DONE.
REQ-031 bus_err SHALL remain set until err_clr is 1. If a timeout and err_clr occur in the same cycle, the set SHALL win.
REQ-032 Instruction and MDR SHALL hold their values between loads.

Reset
REQ-033 When rst=0, the block SHALL immediately, without waiting for clk, enter IDLE and set the following to 0: Mem_req, Mem_we, Mem_addr, Mem_wdata, Instruction, MDR, bus_err and the wait counter.
REQ-034 A reset asserted during BUSY SHALL drop Mem_req in the same cycle and discard the access; a later Mem_ack SHALL have no effect.
REQ-035 After rst rises, the first access SHALL be recognised on the first clock edge at which a strobe is present in IDLE.

Verification
REQ-036 Fetch, zero-wait: MemRead=1, IRWrite=1, Address=0x00000104; Mem_ack=1 on the first Mem_req cycle with Mem_rdata=0x8C220004 -> Mem_addr=0x00000104, mem_stall high for 2 cycles, Instruction=0x8C220004 in DONE, MDR unchanged.
REQ-037 Store with 3 wait cycles: MemWrite=1, Address=0x00000203, Write_data=0xDEADBEEF -> Mem_addr=0x00000200, Mem_we=1, Mem_wdata=0xDEADBEEF for 4 Mem_req cycles, mem_stall high 5 cycles, Instruction and MDR unchanged.
REQ-038 Timeout with TIMEOUT=4: data read, Mem_ack held 0 -> Mem_req high exactly 4 cycles, then bus_err=1 and MDR=0; err_clr pulse -> bus_err=0.
REQ-039 Reset mid-access: rst=0 in the 2nd BUSY cycle -> Mem_req=0 before the next edge and all outputs 0; Mem_ack=1 after reset -> Instruction and MDR remain 0.
REQ-040 Read/write conflict and DONE strobe: MemRead=MemWrite=1 -> Mem_we=0 and MDR loaded. Strobes held through DONE -> exactly one access issued per IDLE recognition.
